// File: rtl/rca_accum.sv
// Accumulates 5-bit {c_out,s} results from a ripple-carry adder over a job of len beats.
// Define RCA_ACCUM_SAT_EN to clamp acc at full scale on overflow instead of wrapping.
module rca_accum #(
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       len,
  input  logic [3:0]       s,
  input  logic             c_out,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc,
  output logic             ovf,
  output logic [3:0]       beats,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       cnt;
  logic             take;
  logic             job_load;
  logic [ACC_W:0]   beat_ext;
  logic [ACC_W:0]   sum;

`ifdef RCA_ACCUM_SAT_EN
  // Inputs are non-negative, so once clamped every later carry re-clamps.
  function automatic logic [ACC_W-1:0] acc_update(input logic [ACC_W:0] sum_in);
    if (sum_in[ACC_W]) return '1;
    return sum_in[ACC_W-1:0];
  endfunction
`else
  function automatic logic [ACC_W-1:0] acc_update(input logic [ACC_W:0] sum_in);
    return sum_in[ACC_W-1:0];
  endfunction
`endif

  assign take     = (state == RUN) && in_valid;
  assign job_load = (state == IDLE) && start && (len != 4'd0);
  assign beat_ext = {{(ACC_W-4){1'b0}}, c_out, s};
  assign sum      = {1'b0, acc} + beat_ext;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (job_load) state_nxt = RUN;
      RUN:     if (take && (cnt == 4'd1)) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == RUN);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // Job registers: loaded on a legal start, stepped on each accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      acc   <= '0;
      ovf   <= 1'b0;
      beats <= '0;
    end else if (job_load) begin
      cnt   <= len;
      acc   <= '0;
      ovf   <= 1'b0;
      beats <= '0;
    end else if (take) begin
      cnt   <= cnt - 4'd1;
      acc   <= acc_update(sum);
      ovf   <= ovf | sum[ACC_W];
      beats <= beats + 4'd1;
    end
  end

endmodule

// File: tb/tb_rca_accum.sv
// Scoreboard bench for rca_accum: drivers push expected job results, a monitor checks them.
module tb_rca_accum;
  localparam int ACC_W = 8;
  localparam int MAXV  = (1 << ACC_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [3:0]       len = '0;
  logic [3:0]       s = '0;
  logic             c_out = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic [3:0]       beats;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             busy;

  typedef struct {
    int acc;
    int ovf;
    int beats;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  rca_accum #(.ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .s(s), .c_out(c_out),
    .in_valid(in_valid), .in_ready(in_ready), .acc(acc), .ovf(ovf),
    .beats(beats), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Reference: the job total is the plain sum of the beat values.
  function automatic int model_acc(input int total);
`ifdef RCA_ACCUM_SAT_EN
    return (total > MAXV) ? MAXV : total;
`else
    return total % (MAXV + 1);
`endif
  endfunction

  // Monitor: every result handshake must match the oldest expected job.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got acc %0d with no job pending", acc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_acc", int'(acc), e.acc);
        chk("sb_ovf", int'(ovf), e.ovf);
        chk("sb_beats", int'(beats), e.beats);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int n);
    start = 1'b1;
    len   = 4'(n);
    tick();
    start = 1'b0;
    len   = '0;
  endtask

  task automatic send(input int v, input int gap);
    int guard;
    repeat (gap) tick();
    in_valid      = 1'b1;
    {c_out, s}    = 5'(v);
    guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) chk("in_ready_timeout", int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic finish_job(input int total, input int n, input int hold);
    exp_t e;
    int   snap;
    e.acc   = model_acc(total);
    e.ovf   = (total > MAXV) ? 1 : 0;
    e.beats = n;
    exp_q.push_back(e);
    chk("out_valid_latency", int'(out_valid), 1);
    snap = int'(acc);
    for (int i = 0; i < hold; i++) begin
      chk("hold_out_valid", int'(out_valid), 1);
      chk("hold_acc_stable", int'(acc), snap);
      tick();
    end
    out_ready = 1'b1;
    start = 1'b1;
    len   = 4'd3;
    tick();
    start = 1'b0;
    len   = '0;
    chk("idle_after_done", int'(busy), 0);
    chk("out_valid_fall", int'(out_valid), 0);
    chk("acc_retained", int'(acc), e.acc);
  endtask

  task automatic run_job(input int vals[$], input int gap, input bit rnd_gap, input int hold);
    int total;
    total = 0;
    out_ready = (hold == 0);
    start_job(vals.size());
    foreach (vals[i]) begin
      total += vals[i];
      send(vals[i], rnd_gap ? int'($urandom_range(0, gap)) : gap);
    end
    finish_job(total, vals.size(), hold);
  endtask

  initial begin
    int vals[$];
    int total;

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_acc", int'(acc), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_beats", int'(beats), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);

    // Basic job and backpressured job
    vals = '{3, 8, 14, 18};
    run_job(vals, 0, 1'b0, 0);
    chk("basic_acc", int'(acc), 43);
    run_job(vals, 2, 1'b0, 5);
    chk("bp_acc", int'(acc), 43);

    // Overflow job
    vals.delete();
    for (int i = 0; i < 15; i++) vals.push_back(31);
    out_ready = 1'b1;
    start_job(15);
    foreach (vals[i]) send(vals[i], 0);
`ifdef RCA_ACCUM_SAT_EN
    chk("ovf_acc", int'(acc), 255);
`else
    chk("ovf_acc", int'(acc), 209);
`endif
    chk("ovf_flag", int'(ovf), 1);
    finish_job(465, 15, 0);

    // Illegal starts
    start_job(0);
    chk("len0_busy", int'(busy), 0);
    chk("len0_in_ready", int'(in_ready), 0);
    start_job(4);
    send(3, 0);
    start_job(5);
    chk("run_start_beats", int'(beats), 1);
    chk("run_start_in_ready", int'(in_ready), 1);
    send(8, 0);
    send(14, 0);
    send(18, 0);
    finish_job(43, 4, 0);

    // Reset mid-job
    start_job(4);
    send(3, 0);
    send(8, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_acc", int'(acc), 0);
    chk("midrst_beats", int'(beats), 0);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    repeat (3) tick();
    chk("midrst_no_done", int'(out_valid), 0);
    vals = '{5};
    run_job(vals, 0, 1'b0, 0);
    chk("after_rst_acc", int'(acc), 5);

    // Random jobs
    for (int j = 0; j < 25; j++) begin
      int n;
      n = int'($urandom_range(1, 15));
      vals.delete();
      total = 0;
      for (int k = 0; k < n; k++) vals.push_back(int'($urandom_range(0, 31)));
      run_job(vals, 2, 1'b1, int'($urandom_range(0, 3)));
    end

    repeat (2) tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rca_accum.md
RCA_ACCUM -- requirements
Module: rca_accum

Interface
REQ-001 Parameter ACC_W, default 8: accumulator and result width in bits; legal range 6..16.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
REQ-004 start  input  1  one-cycle request to begin a new accumulation job.
REQ-005 len  input  4  number of adder results in the job, sampled with start; 1..15 legal.
REQ-006 s  input  4  sum from the upstream ripple-carry adder.
REQ-007 c_out  input  1  carry from the upstream ripple-carry adder.
REQ-008 in_valid  input  1  s/c_out hold a valid adder result.
REQ-009 in_ready  output  1  block accepts a result this cycle.
REQ-010 acc  output  ACC_W  accumulated total.
REQ-011 ovf  output  1  sticky overflow: the total exceeded the ACC_W range during the job.
REQ-012 beats  output  4  results accepted so far in the current job.
REQ-013 out_valid  output  1  acc/ovf/beats hold the final job result.
REQ-014 out_ready  input  1  downstream consumes the result.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN and DONE; every output SHALL be a registered output or a decode of the state register.
REQ-017 In IDLE, start=1 with len!=0 SHALL load cnt=len, clear acc, ovf and beats, and enter RUN on the next cycle.
REQ-018 In IDLE, start=1 with len==0 SHALL be ignored; the FSM stays in IDLE.
REQ-019 start SHALL be ignored in RUN and DONE.
REQ-020 in_ready SHALL be 1 only in RUN; a result SHALL be accepted only on a cycle with in_valid and in_ready both high.
REQ-021 Each accepted result SHALL be taken as the 5-bit value {c_out,s}, zero-extended to ACC_W+1 bits, and added to acc.
REQ-022 On each accepted result, beats SHALL increment and cnt SHALL decrement.
REQ-023 When the sum exceeds 2^ACC_W-1, ovf SHALL be set and stay set until the next job starts or reset; acc wraps modulo 2^ACC_W (see REQ-034 for the saturating variant).
REQ-024 When the result that brings cnt to 0 is accepted, the FSM SHALL enter DONE on the next edge.
- out_valid SHALL be 1 from that cycle on; latency from the final accepted result to out_valid is 1 cycle.
REQ-025 Cycles with in_valid=0 in RUN SHALL hold all state unchanged; gaps of any length are legal.
REQ-026 In DONE, acc, ovf and beats SHALL hold stable while out_valid=1 and out_ready=0.
REQ-027 In DONE with out_ready=1, the FSM SHALL return to IDLE on the next edge, and out_valid SHALL fall.
- acc, ovf and beats SHALL retain their values until the next job starts.
REQ-028 A start in the same cycle as the DONE->IDLE handshake SHALL be ignored; a new job needs start in IDLE.

Reset
REQ-029 rst=1 SHALL force IDLE and set acc=0, ovf=0, beats=0, cnt=0, in_ready=0, out_valid=0 and busy=0 at the next edge.
REQ-030 rst SHALL take priority over start, in_valid and out_ready in the same cycle.
REQ-031 rst during RUN or DONE SHALL discard the partial or final result; no out_valid SHALL follow.

Configuration
REQ-032 The macro RCA_ACCUM_SAT_EN SHALL select the overflow behaviour.
REQ-033 Without RCA_ACCUM_SAT_EN, acc SHALL wrap modulo 2^ACC_W on overflow.
REQ-034 With RCA_ACCUM_SAT_EN defined, acc SHALL clamp to 2^ACC_W-1 on overflow and remain clamped for the rest of the job.
- ovf SHALL behave identically in both builds.

Verification
REQ-035 The bench SHALL cover these directed scenarios (ACC_W=8):
- Basic job: start with len=4, then results {c_out,s} = 3, 8, 14, 18 back-to-back -> acc=43 (0x2B), ovf=0, beats=4, out_valid 1 cycle after the 4th result.
- Backpressure: same job with in_valid idle 2 cycles between results, and out_ready held low 5 cycles in DONE -> acc=43, outputs stable, FSM returns to IDLE the cycle after out_ready=1.
- Overflow: len=15 with every result 31 -> total 465, so acc=209 (0xD1) and ovf=1; with RCA_ACCUM_SAT_EN defined, acc=255 and ovf=1.
- Illegal start: start with len=0, and start pulsed during RUN -> no state change, in_ready stays as before, beats unaffected.
- Reset mid-job: rst after 2 of 4 results -> next cycle IDLE with acc=0, beats=0, out_valid=0; a following len=1 job with result 5 gives acc=5.
